// File: rtl/aes_dec_pkg.sv
// Shared types, the inverse S-box table and the InvShiftRows wiring for the AES
// decrypt datapath. Byte k of a state sits at [127-8k -: 8] and is row k%4, column k/4.
package aes_dec_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stage_state_t;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

  // Row r rotates right by r columns: destination column c takes source column c-r.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * byte_idx(row, col) -: 8] = s[127 - 8 * byte_idx(row, (col - row + 4) % 4) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, table lookup.
module inv_sbox
  import aes_dec_pkg::*;
(
  input  aes_byte_t byteIn,
  output aes_byte_t byteOut
);

  assign byteOut = INV_SBOX[byteIn];

endmodule

// File: rtl/inv_shift_sub_stage.sv
// Decrypt stage: InvShiftRows at accept time, then InvSubBytes over LANES S-boxes per
// cycle, in place in the work register. The finished block waits in work for out_ready.
module inv_shift_sub_stage
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  stage_state_t  state;
  stage_state_t  nextState;
  logic [CW-1:0] cnt;
  aes_state_t    work;
  aes_state_t    workNext;
  aes_byte_t     laneIn  [LANES];
  aes_byte_t     laneOut [LANES];
  logic          accept;
  logic          xfer;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_state = work;

  // Lane g serves byte cnt*LANES+g of the current group.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    assign laneIn[g] = work[127 - 8 * (int'(cnt) * LANES + g) -: 8];
    inv_sbox uSbox (
      .byteIn (laneIn[g]),
      .byteOut(laneOut[g])
    );
  end

  always_comb begin
    workNext = work;
    for (int i = 0; i < LANES; i++) begin
      workNext[127 - 8 * (int'(cnt) * LANES + i) -: 8] = laneOut[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = RUN;
      RUN:     if (cnt == LAST) nextState = DONE;
      DONE:    if (xfer) nextState = accept ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: in_ready = rst_n;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // abort only restarts the counter; work keeps whatever it held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      work <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (accept) begin
      work <= inv_shift_rows(in_state);
      cnt  <= '0;
    end else if (state == RUN) begin
      work <= workNext;
      if (cnt != LAST) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_inv_shift_sub_stage.sv
// Directed bench for inv_shift_sub_stage (LANES=4) plus a random sweep over LANES=1,2,8,16
// against an inverse S-box derived independently from GF(2^8) arithmetic.
module tb_inv_shift_sub_stage;

  localparam logic [127:0] VEC_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_OUT  = 128'h52f3a3383009d79ebf366afb8140a5d5;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_52   = {16{8'h52}};
  localparam int           SW_LANES [4] = '{1, 2, 8, 16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort;
  logic         inValid;
  logic         inReady;
  logic [127:0] inState;
  logic         outValid;
  logic         outReady;
  logic [127:0] outState;
  logic         busy;

  logic         swAbort;
  logic         swOutReady;
  logic [127:0] swIn;
  logic         swValid    [4];
  logic         swReady    [4];
  logic         swOutValid [4];
  logic [127:0] swOut      [4];
  logic         swBusy     [4];

  int           nChecks = 0;
  int           nFail   = 0;
  logic [7:0]   invTab [256];

  always #5 clk = ~clk;

  inv_shift_sub_stage #(.LANES(4)) uDut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_state (inState),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_state(outState),
    .busy     (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : gSweep
    inv_shift_sub_stage #(.LANES(SW_LANES[g])) uDut (
      .clk      (clk),
      .rst_n    (rst_n),
      .abort    (swAbort),
      .in_valid (swValid[g]),
      .in_ready (swReady[g]),
      .in_state (swIn),
      .out_valid(swOutValid[g]),
      .out_ready(swOutReady),
      .out_state(swOut[g]),
      .busy     (swBusy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box = affine(GF inverse); the table here is its inverse.
  task automatic buildModel();
    logic [7:0] b, s, inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      invTab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] modelOut(input logic [127:0] s);
    logic [127:0] r;
    int src, dst;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        dst = 4 * c + row;
        src = 4 * ((c - row + 4) % 4) + row;
        r[127 - 8 * dst -: 8] = invTab[s[127 - 8 * src -: 8]];
      end
    end
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge where out_valid is first seen.
  task automatic runBlock(input string tag, input logic [127:0] din,
                          input logic [127:0] exp, input int expLat);
    int k;
    check({tag, " in_ready"}, 128'(inReady), 128'(1));
    inValid = 1'b1;
    inState = din;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inState = ~din;
    check({tag, " busy"}, 128'(busy), 128'(1));
    k = 0;
    while (!outValid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 128'(k), 128'(expLat));
    check({tag, " data"}, outState, exp);
  endtask

  task automatic sweepRun(input int g);
    logic [127:0] din, exp;
    int k;
    for (int b = 0; b < 50; b++) begin
      din = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = modelOut(din);
      swIn = din;
      swValid[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      swValid[g] = 1'b0;
      k = 0;
      while (!swOutValid[g] && k < 40) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("sweep L%0d latency", SW_LANES[g]), 128'(k), 128'(16 / SW_LANES[g]));
      check($sformatf("sweep L%0d data", SW_LANES[g]), swOut[g], exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stayLow;
    rst_n      = 1'b0;
    abort      = 1'b0;
    inValid    = 1'b0;
    inState    = '0;
    outReady   = 1'b1;
    swAbort    = 1'b0;
    swOutReady = 1'b1;
    swIn       = '0;
    for (int g = 0; g < 4; g++) swValid[g] = 1'b0;
    buildModel();

    // Reset values
    #1;
    check("reset out_valid", 128'(outValid), 128'(0));
    check("reset in_ready", 128'(inReady), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 128'(inReady), 128'(1));
    @(negedge clk);

    // All-0x63 block and the reference vector
    runBlock("all63", ALL_63, 128'h0, 4);
    @(negedge clk);
    runBlock("vector", VEC_IN, VEC_OUT, 4);
    @(negedge clk);

    // Back-pressure: result held, nothing accepted while a new block is offered
    outReady = 1'b0;
    runBlock("bp", 128'h0, ALL_52, 4);
    inValid = 1'b1;
    inState = VEC_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp out_valid", 128'(outValid), 128'(1));
      check("bp in_ready", 128'(inReady), 128'(0));
      check("bp out_state", outState, ALL_52);
    end
    // Transfer and accept on the same edge
    outReady = 1'b1;
    #1;
    runBlock("b2b", VEC_IN, VEC_OUT, 4);
    @(negedge clk);

    // abort on the second RUN cycle
    inValid = 1'b1;
    inState = ALL_63;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    check("abort pre busy", 128'(busy), 128'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 128'(busy), 128'(0));
    check("abort in_ready", 128'(inReady), 128'(1));
    stayLow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (outValid) stayLow = 1'b0;
      @(negedge clk);
    end
    check("abort out_valid never", 128'(stayLow), 128'(1));

    // abort wins over a same-cycle accept
    inValid = 1'b1;
    inState = ALL_63;
    abort   = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    abort   = 1'b0;
    check("abort+accept busy", 128'(busy), 128'(0));
    check("abort+accept in_ready", 128'(inReady), 128'(1));
    runBlock("after abort", VEC_IN, VEC_OUT, 4);
    @(negedge clk);

    // Asynchronous reset between edges while in RUN
    inValid = 1'b1;
    inState = VEC_IN;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    check("areset pre busy", 128'(busy), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset busy", 128'(busy), 128'(0));
    check("areset out_valid", 128'(outValid), 128'(0));
    check("areset in_ready", 128'(inReady), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stayLow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid) stayLow = 1'b0;
    end
    check("areset no partial output", 128'(stayLow), 128'(1));
    runBlock("after areset", ALL_63, 128'h0, 4);
    @(negedge clk);

    // LANES sweep against the model
    for (int g = 0; g < 4; g++) sweepRun(g);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
